dsp48a1_mac_seq: RTL and testbench

//  Sequencer that drives one DSP48A1 slice as a signed dot-product engine: sum(a[i]*b[i]), i=0..LEN-1.

---
 rtl/dsp_mac_seq_pkg.sv | 26 ++
 rtl/dsp_mac_seq_sat.sv | 26 ++
 rtl/dsp48a1_mac_seq.sv | 172 +++++++++++++++++
 tb/tb_dsp48a1_mac_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_seq_pkg.sv
// rtl/dsp_mac_seq_pkg.sv - shared states and OPMODE tags for the DSP48A1 MAC sequencer
package dsp_mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    DRAIN = 3'd2,
    WAIT  = 3'd3,
    ZERO  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] OPM_FIRST   = 8'h01;
  localparam logic [7:0] OPM_ACC     = 8'h09;
  localparam logic [7:0] OPM_BUBBLE  = 8'h08;
  localparam int         OPM_SUB_BIT = 7;

  // First beat starts from Z=0 so stale P from a previous job never leaks in.
  function automatic logic [7:0] beat_tag(input logic first, input logic sub);
    logic [7:0] tag;
    tag = first ? OPM_FIRST : OPM_ACC;
    tag[OPM_SUB_BIT] = sub;
    return tag;
  endfunction

endpackage

// File: rtl/dsp_mac_seq_sat.sv
// rtl/dsp_mac_seq_sat.sv - combinational signed clamp of the 48-bit accumulator to SAT_W bits
module dsp_mac_seq_sat #(
  parameter int SAT_W = 36
) (
  input  logic [47:0] din,
  output logic [47:0] dout,
  output logic        sat
);

  localparam logic [47:0] MAX_V = (48'd1 << (SAT_W - 1)) - 48'd1;
  localparam logic [47:0] MIN_V = ~MAX_V;

  logic fits;

  // Value fits when every bit above the SAT_W sign bit repeats the sign.
  assign fits = (din[47:SAT_W-1] == {(49 - SAT_W){din[47]}});

  always_comb begin
    sat  = ~fits;
    dout = din;
    if (!fits) begin
      dout = din[47] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/dsp48a1_mac_seq.sv
// rtl/dsp48a1_mac_seq.sv - DSP48A1 dot-product sequencer; DSP_MAC_SAT_EN enables result clamping
module dsp48a1_mac_seq
  import dsp_mac_seq_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int DSP_LAT = 3,
  parameter int SAT_W   = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_sub,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [17:0]       in_a,
  input  logic [17:0]       in_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [47:0]       res_data,
  output logic              res_carry,
  output logic              res_sat,
  output logic [17:0]       dsp_a,
  output logic [17:0]       dsp_b,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_ce,
  output logic              dsp_rstp,
  input  logic [47:0]       dsp_p,
  input  logic              dsp_carryout
);

  if (DSP_LAT < 2 || DSP_LAT > 17) begin : g_bad_lat
    $error("DSP_LAT out of range");
  end
  if (SAT_W < 2 || SAT_W > 48) begin : g_bad_sat_w
    $error("SAT_W out of range");
  end

  localparam logic [3:0] DRAIN_LAST = 4'(DSP_LAT - 2);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q;
  logic             first_q;
  logic             sub_q;
  logic [3:0]       drain_q;
  logic [7:0]       opm_q;
  logic [7:0]       tag;
  logic             accept;
  logic             advance;
  logic [47:0]      cap_data;
  logic             cap_sat;
  logic [47:0]      res_data_q;
  logic             res_carry_q;
  logic             res_sat_q;

`ifdef DSP_MAC_SAT_EN
  dsp_mac_seq_sat #(
    .SAT_W (SAT_W)
  ) u_sat (
    .din  (dsp_p),
    .dout (cap_data),
    .sat  (cap_sat)
  );
`else
  assign cap_data = dsp_p;
  assign cap_sat  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    in_ready  = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    dsp_a     = '0;
    dsp_b     = '0;
    tag       = OPM_BUBBLE;
    dsp_rstp  = rst;
    res_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = (cfg_len != '0) ? FEED : ZERO;
        end
      end
      FEED: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          advance = 1'b1;
          dsp_a   = in_a;
          dsp_b   = in_b;
          tag     = beat_tag(first_q, sub_q);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Zero operands with a P+0 tag push the last real product through M and P.
        advance = 1'b1;
        if (drain_q == DRAIN_LAST) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d = DONE;
      end
      ZERO: begin
        dsp_rstp = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dsp_ce     = advance;
  assign dsp_opmode = opm_q;
  assign res_data   = res_data_q;
  assign res_carry  = res_carry_q;
  assign res_sat    = res_sat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      sub_q       <= 1'b0;
      drain_q     <= '0;
      opm_q       <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        cnt_q   <= cfg_len;
        first_q <= 1'b1;
        sub_q   <= cfg_sub;
      end
      if (accept) begin
        cnt_q   <= cnt_q - LEN_W'(1);
        first_q <= 1'b0;
      end
      drain_q <= (state_q == DRAIN) ? drain_q + 4'd1 : 4'd0;
      // One-step delay so the slice's OPMODE register meets the matching M value.
      if (advance) begin
        opm_q <= tag;
      end
      if (state_q == WAIT) begin
        res_data_q  <= cap_data;
        res_carry_q <= dsp_carryout;
        res_sat_q   <= cap_sat;
      end else if (state_q == ZERO) begin
        res_data_q  <= '0;
        res_carry_q <= 1'b0;
        res_sat_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// tb/tb_dsp48a1_mac_seq.sv - directed bench for dsp48a1_mac_seq with a behavioural DSP48A1 slice
module tb_dsp48a1_mac_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic        cfg_sub = 1'b0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] in_a = '0;
  logic [17:0] in_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [47:0] res_data;
  logic        res_carry;
  logic        res_sat;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce;
  logic        dsp_rstp;
  logic [47:0] dsp_p;
  logic        dsp_carryout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dsp48a1_mac_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_len      (cfg_len),
    .cfg_sub      (cfg_sub),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_carry    (res_carry),
    .res_sat      (res_sat),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_opmode   (dsp_opmode),
    .dsp_ce       (dsp_ce),
    .dsp_rstp     (dsp_rstp),
    .dsp_p        (dsp_p),
    .dsp_carryout (dsp_carryout)
  );

  // Slice model: A1/B1 -> M -> P, OPMODE registered, all gated by one CE.
  logic signed [17:0] s_a1 = '0;
  logic signed [17:0] s_b1 = '0;
  logic signed [35:0] s_m  = '0;
  logic [7:0]         s_op = '0;
  logic [47:0]        s_p  = '0;
  logic               s_co = 1'b0;
  logic [47:0]        s_x, s_z;
  logic [48:0]        s_sum;

  always_comb begin
    s_x   = (s_op[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0;
    s_z   = (s_op[3:2] == 2'b10) ? s_p : 48'd0;
    s_sum = s_op[7] ? ({1'b0, s_z} - {1'b0, s_x}) : ({1'b0, s_z} + {1'b0, s_x});
  end

  always @(posedge clk) begin
    if (dsp_ce) begin
      s_a1 <= dsp_a;
      s_b1 <= dsp_b;
      s_m  <= s_a1 * s_b1;
      s_op <= dsp_opmode;
    end
    if (dsp_rstp) begin
      s_p  <= '0;
      s_co <= 1'b0;
    end else if (dsp_ce) begin
      s_p  <= s_sum[47:0];
      s_co <= s_sum[48];
    end
  end

  assign dsp_p        = s_p;
  assign dsp_carryout = s_co;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int va[8];
  int vb[8];

  // Runs one job up to res_valid; lat = negedges from final accept to res_valid.
  task automatic run_job(input string tag, input int len, input logic sub, input int gap,
                         output int lat);
    int ce_bad;
    logic [7:0] exp_op;
    ce_bad = 0;
    @(negedge clk);
    start = 1'b1; cfg_len = 16'(len); cfg_sub = sub;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          in_valid = 1'b0;
          #1;
          if (dsp_ce) ce_bad++;
          @(negedge clk);
        end
      end
      in_valid = 1'b1; in_a = 18'(va[i]); in_b = 18'(vb[i]);
      @(negedge clk);
      in_valid = 1'b0; in_a = '0; in_b = '0;
      exp_op = (i == 0) ? 8'h01 : 8'h09;
      exp_op[7] = sub;
      check({tag, "_opmode"}, 64'(dsp_opmode), 64'(exp_op));
    end
    if (gap > 0) check({tag, "_gap_ce"}, 64'(ce_bad), 64'd0);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_valid"}, 64'(res_valid), 64'd0);
  endtask

  task automatic load_t1();
    va[0] = 2;  vb[0] = 3;
    va[1] = 4;  vb[1] = 5;
    va[2] = -1; vb[2] = 7;
  endtask

  initial begin
    int lat;
    int seen;
    int bad;
    logic [47:0] held;

    repeat (2) @(negedge clk);
    check("rst_rstp", 64'(dsp_rstp), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_opmode", 64'(dsp_opmode), 64'd0);
    check("rst_ce", 64'(dsp_ce), 64'd0);
    check("rst_rstp_low", 64'(dsp_rstp), 64'd0);

    // 2*3 + 4*5 + (-1)*7 = 19; last add of a negative product carries out.
    load_t1();
    run_job("t1", 3, 1'b0, 0, lat);
    check("t1_lat", 64'(lat), 64'd3);
    check("t1_data", 64'(res_data), 64'h13);
    check("t1_carry", 64'(res_carry), 64'd1);
    check("t1_sat", 64'(res_sat), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    handshake("t1");

    // -(10*10) - 3*3 = -109
    va[0] = 10; vb[0] = 10;
    va[1] = 3;  vb[1] = 3;
    run_job("t2", 2, 1'b1, 0, lat);
    check("t2_lat", 64'(lat), 64'd3);
    check("t2_data", 64'(res_data), 64'hFFFF_FFFF_FF93);
    handshake("t2");

    load_t1();
    run_job("t3", 3, 1'b0, 2, lat);
    check("t3_lat", 64'(lat), 64'd3);
    check("t3_data", 64'(res_data), 64'h13);
    handshake("t3");

    // Backpressure on the result; start pulses must be ignored.
    load_t1();
    run_job("t4", 3, 1'b0, 0, lat);
    held = res_data;
    check("t4_data", 64'(held), 64'h13);
    bad = 0;
    repeat (5) begin
      start = 1'b1; cfg_len = 16'd0;
      @(negedge clk);
      if (!res_valid || res_data != 48'h13 || in_ready) bad++;
    end
    start = 1'b0;
    check("t4_hold", 64'(bad), 64'd0);
    handshake("t4");
    @(negedge clk);
    check("t4_stay_idle", 64'(busy), 64'd0);

    // Zero-length job after a carry-out result.
    @(negedge clk);
    start = 1'b1; cfg_len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check("t5_rstp", 64'(dsp_rstp), 64'd1);
    check("t5_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t5_valid", 64'(res_valid), 64'd1);
    check("t5_data", 64'(res_data), 64'd0);
    check("t5_carry", 64'(res_carry), 64'd0);
    handshake("t5");

    // Reset in the middle of FEED.
    start = 1'b1; cfg_len = 16'd3; cfg_sub = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_a = 18'd2; in_b = 18'd3;
    @(negedge clk);
    in_a = 18'd4; in_b = 18'd5; rst = 1'b1;
    @(negedge clk);
    check("t5r_busy", 64'(busy), 64'd0);
    check("t5r_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("t5r_no_result", 64'(seen), 64'd0);

    load_t1();
    run_job("t5r_rerun", 3, 1'b0, 0, lat);
    check("t5r_rerun_data", 64'(res_data), 64'h13);
    handshake("t5r_rerun");

`ifdef DSP_MAC_SAT_EN
    for (int i = 0; i < 4; i++) begin
      va[i] = 131071; vb[i] = 131071;
    end
    run_job("t6", 4, 1'b0, 0, lat);
    check("t6_data", 64'(res_data), 64'h0007_FFFF_FFFF);
    check("t6_sat", 64'(res_sat), 64'd1);
    handshake("t6");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
